// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Instruction-memory fetch bus between the fetch unit and instruction memory.
//
//   Handshake: the fetch unit raises imem_req with a word address on
//   imem_addr and keeps both stable until memory answers with imem_ack.
//   imem_rdata is valid in the same cycle as imem_ack. The word is taken on
//   the clock edge that samples imem_ack high, and imem_req drops right after
//   that edge. imem_ack seen while no request is outstanding is ignored.
//
//   Signals:
//     imem_req    fetch request              (master -> slave)
//     imem_addr   word address, ADDR_W bits  (master -> slave)
//     imem_ack    response valid             (slave  -> master)
//     imem_rdata  instruction word, 32 bits  (slave  -> master)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Multi-cycle instruction fetch and PC sequencer. It holds the PC and the
//   instruction register, fetches words over the imem interface, presents
//   opcode/func to the control unit, and on each rising edge of updPC
//   resolves the branch selected by brOp and fetches the next instruction.
//
//   Optional feature: define IFU_RETIRE_CNT_EN to add a 32-bit retire_cnt
//   output counting accepted updPC edges (wraps at 2^32).
//
//   Ports:
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     updPC         PC-update strobe; only its rising edge in S_HOLD counts
//     brOp          branch condition, sampled with the updPC edge
//     flag_neg      ALU negative flag, sampled with brOp
//     flag_zero     ALU zero flag, sampled with brOp
//     imem          instruction-memory bus (master side)
//     instr         instruction register
//     opcode        instr[31:26]
//     func          instr[4:0]
//     pc            address of the instruction held in instr
//     instr_valid   instr is stable and decodable
//     dbg_state     current FSM state (S_FETCH=0, S_WAIT=1, S_HOLD=2)
//     retire_cnt    accepted update count (IFU_RETIRE_CNT_EN only)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                updPC,
  input  logic [2:0]          brOp,
  input  logic                flag_neg,
  input  logic                flag_zero,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic [4:0]          func,
  output logic [ADDR_W-1:0]   pc,
  output logic                instr_valid,
  output logic [1:0]          dbg_state
`ifdef IFU_RETIRE_CNT_EN
  ,
  output logic [31:0]         retire_cnt
`endif
);

  localparam logic [31:0] NOP_INSTR = 32'h9400_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              updpc_prev_q, updpc_prev_d;
`ifdef IFU_RETIRE_CNT_EN
  logic [31:0]       retire_q, retire_d;
`endif

  logic              upd_edge;
  logic              taken;
  logic [ADDR_W-1:0] offset_ext;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] tgt_pc;
  logic [ADDR_W-1:0] next_pc;

  // The edge detector tracks updPC in every state, so a level that is
  // already high when S_HOLD is entered never looks like a new edge.
  assign updpc_prev_d = updPC;
  assign upd_edge     = updPC & ~updpc_prev_q;

  // Branch resolution. The 16-bit offset is sign-extended (or truncated)
  // to ADDR_W; all PC arithmetic wraps modulo 2^ADDR_W.
  always_comb begin
    offset_ext = ADDR_W'($signed(instr_q[15:0]));
    seq_pc     = pc_q + ADDR_W'(1);
    tgt_pc     = seq_pc + offset_ext;
    case (brOp)
      3'b000:  taken = 1'b1;
      3'b001:  taken = flag_neg;
      3'b010:  taken = ~flag_neg & ~flag_zero;
      3'b011:  taken = flag_zero;
      default: taken = 1'b0;
    endcase
    next_pc = taken ? tgt_pc : seq_pc;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  if (imem.imem_ack) state_d = S_HOLD;
      S_HOLD:  if (upd_edge) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // FSM output / datapath next values
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    req_d    = req_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
`ifdef IFU_RETIRE_CNT_EN
    retire_d = retire_q;
`endif
    case (state_q)
      S_FETCH: begin
        req_d  = 1'b1;
        addr_d = pc_q;
      end
      S_WAIT: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (upd_edge) begin
          pc_d     = next_pc;
          valid_d  = 1'b0;
`ifdef IFU_RETIRE_CNT_EN
          retire_d = retire_q + 32'd1;
`endif
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers. imem_req is a flop so reset drops it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      valid_q      <= 1'b0;
      updpc_prev_q <= 1'b0;
`ifdef IFU_RETIRE_CNT_EN
      retire_q     <= 32'd0;
`endif
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      updpc_prev_q <= updpc_prev_d;
`ifdef IFU_RETIRE_CNT_EN
      retire_q     <= retire_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[31:26];
  assign func           = instr_q[4:0];
  assign pc             = pc_q;
  assign instr_valid    = valid_q;
  assign dbg_state      = state_q;
`ifdef IFU_RETIRE_CNT_EN
  assign retire_cnt     = retire_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Bench for instr_fetch_unit (ADDR_W = 16, RESET_PC = 0). A memory
//   responder serves fetches with a programmable or random ack delay and
//   checks every requested address against a queue of expected fetch
//   addresses. A reference model computes the next PC from the branch rules
//   with plain integer arithmetic modulo 2^16.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int ADDR_W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic              updpc;
  logic [2:0]        br_op;
  logic              flag_n;
  logic              flag_z;
  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [4:0]        func;
  logic [ADDR_W-1:0] pc;
  logic              instr_valid;
  logic [1:0]        dbg_state;
`ifdef IFU_RETIRE_CNT_EN
  logic [31:0]       retire_cnt;
`endif

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) m_if ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .updPC       (updpc),
    .brOp        (br_op),
    .flag_neg    (flag_n),
    .flag_zero   (flag_z),
    .imem        (m_if),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .pc          (pc),
    .instr_valid (instr_valid),
    .dbg_state   (dbg_state)
`ifdef IFU_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [ADDR_W-1:0] exp_q[$];     // expected fetch addresses, in order
  logic [ADDR_W-1:0] exp_pc;
  int unsigned       exp_retire;
  logic [31:0]       mem [0:65535];

  int fixed_delay = 2;             // < 0 selects a random delay per fetch
  bit ack_noise   = 1'b0;          // random ack pulses while no request
  bit in_req      = 1'b0;
  int wait_cnt    = 0;
  int cur_delay   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [ADDR_W-1:0] model_next(input logic [ADDR_W-1:0] cur,
                                                   input logic [31:0] iw,
                                                   input logic [2:0] br,
                                                   input logic n, input logic z);
    shortint off;
    int      t;
    bit      tk;
    off = shortint'(iw[15:0]);
    case (br)
      3'd0:    tk = 1'b1;
      3'd1:    tk = n;
      3'd2:    tk = !n && !z;
      3'd3:    tk = z;
      default: tk = 1'b0;
    endcase
    t = int'(cur) + 1 + (tk ? int'(off) : 0);
    t = ((t % 65536) + 65536) % 65536;
    return ADDR_W'(t);
  endfunction

  // ---------------- memory responder ----------------
  always @(negedge clk) begin
    if (rst || !m_if.imem_req) begin
      in_req          = 1'b0;
      wait_cnt        = 0;
      m_if.imem_ack   = (!rst && ack_noise) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_if.imem_rdata = $urandom;
    end else begin
      if (!in_req) begin
        in_req    = 1'b1;
        cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end
      check("fetch_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("fetch_addr", 32'(m_if.imem_addr), 32'(exp_q[0]));
      if (wait_cnt >= cur_delay) begin
        m_if.imem_ack   = 1'b1;
        m_if.imem_rdata = mem[m_if.imem_addr];
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        m_if.imem_ack   = 1'b0;
        m_if.imem_rdata = $urandom;
        wait_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid();
    int n;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      if (instr_valid) break;
      n++;
    end
    if (n >= 60) check("valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic check_hold();
    check("pc", 32'(pc), 32'(exp_pc));
    check("instr", instr, mem[exp_pc]);
    check("opcode", 32'(opcode), 32'(mem[exp_pc][31:26]));
    check("func", 32'(func), 32'(mem[exp_pc][4:0]));
    check("valid", 32'(instr_valid), 32'd1);
`ifdef IFU_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, exp_retire);
`endif
  endtask

  task automatic send_upd(input logic [2:0] br, input logic n, input logic z, input int hold);
    @(negedge clk);
    updpc  = 1'b1;
    br_op  = br;
    flag_n = n;
    flag_z = z;
    exp_pc = model_next(exp_pc, mem[exp_pc], br, n, z);
    exp_q.push_back(exp_pc);
    exp_retire++;
    repeat (hold) @(negedge clk);
    updpc  = 1'b0;
    br_op  = 3'($urandom);
    flag_n = 1'($urandom);
    flag_z = 1'($urandom);
  endtask

  task automatic step(input logic [2:0] br, input logic n, input logic z, input int hold);
    send_upd(br, n, z, hold);
    wait_valid();
    check_hold();
  endtask

  task automatic check_reset_state();
    check("rst_req", 32'(m_if.imem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", instr, 32'h9400_0000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", 32'(m_if.imem_addr), 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef IFU_RETIRE_CNT_EN
    check("rst_retire", retire_cnt, 32'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n_wait;

    rst    = 1'b1;
    updpc  = 1'b0;
    br_op  = 3'd0;
    flag_n = 1'b0;
    flag_z = 1'b0;
    m_if.imem_ack   = 1'b0;
    m_if.imem_rdata = 32'h0;
    exp_pc     = '0;
    exp_retire = 0;

    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[0]            = 32'h0422_0005;
    mem[10][15:0]     = 16'hFFFC;
    mem[12][15:0]     = 16'hFFF2;   // 12 + 1 - 14 = 0xFFFF

    repeat (3) @(negedge clk);
    check_reset_state();

    // Reset release: first fetch at address 0, 2-cycle ack delay
    exp_q.push_back(16'h0000);
    fixed_delay = 2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_req", 32'(m_if.imem_req), 32'd1);
    check("first_addr", 32'(m_if.imem_addr), 32'h0);
    wait_valid();
    check("boot_instr", instr, 32'h0422_0005);
    check("boot_opcode", 32'(opcode), 32'h01);
    check("boot_func", 32'(func), 32'h05);
    check_hold();

    // Sequential steps up to pc 5, then 5 -> 6
    fixed_delay = 1;
    for (int i = 0; i < 5; i++) step(3'b100, 1'b0, 1'b0, 1);
    step(3'b100, 1'b1, 1'b1, 1);
    check("seq_pc6", 32'(pc), 32'd6);

    // Conditional branch at pc 10 with offset -4
    for (int i = 0; i < 4; i++) step(3'b111, 1'b1, 1'b0, 1);
    step(3'b011, 1'b0, 1'b1, 1);
    check("bz_taken", 32'(pc), 32'd7);
    for (int i = 0; i < 3; i++) step(3'b101, 1'b0, 1'b1, 2);
    step(3'b011, 1'b1, 1'b0, 1);
    check("bz_not_taken", 32'(pc), 32'd11);

    // BPL with zero set: not taken
    step(3'b010, 1'b0, 1'b1, 1);
    check("bpl_zero", 32'(pc), 32'd12);

    // Unconditional jump to 0xFFFF, then sequential wrap to 0
    step(3'b000, 1'b0, 1'b0, 1);
    check("jump_ffff", 32'(pc), 32'hFFFF);
    step(3'b100, 1'b0, 1'b0, 1);
    check("wrap_zero", 32'(pc), 32'h0);

    // Latency with a 0-wait ack: edge -> valid in 3 cycles
    fixed_delay = 0;
    @(negedge clk);
    updpc  = 1'b1;
    br_op  = 3'b100;
    exp_pc = model_next(exp_pc, mem[exp_pc], 3'b100, 1'b0, 1'b0);
    exp_q.push_back(exp_pc);
    exp_retire++;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (i == 1) updpc = 1'b0;
      if (instr_valid) break;
    end
    check("latency", 32'(lat), 32'd3);
    check_hold();

    // updPC held across fetch and the following S_HOLD entry: one update
    step(3'b100, 1'b0, 1'b0, 6);
    repeat (5) @(negedge clk);
    check("held_pc", 32'(pc), 32'(exp_pc));
    check("held_valid", 32'(instr_valid), 32'd1);
    check("held_no_fetch", 32'(exp_q.size()), 32'd0);
`ifdef IFU_RETIRE_CNT_EN
    check("held_retire", retire_cnt, exp_retire);
`endif

    // Randomized updates with random ack delays and stray acks
    fixed_delay = -1;
    ack_noise   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    ack_noise = 1'b0;

    // Reset during S_WAIT
    fixed_delay = 6;
    send_upd(3'b100, 1'b0, 1'b0, 1);
    n_wait = 0;
    while (!m_if.imem_req && n_wait < 20) begin
      @(posedge clk);
      #1;
      n_wait++;
    end
    check("mid_req_seen", 32'(m_if.imem_req), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(m_if.imem_req), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'h0);
    check("mid_rst_instr", instr, 32'h9400_0000);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    exp_q.delete();
    exp_pc     = '0;
    exp_retire = 0;
    repeat (2) @(negedge clk);
    check_reset_state();
    exp_q.push_back(16'h0000);
    fixed_delay = 1;
    rst = 1'b0;
    wait_valid();
    check_hold();

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
